// File: rtl/d5m_config_seq.sv
// D5M camera register configuration sequencer.
// Walks ROM[FIRST_ADDR..LAST_ADDR] and issues one I2C write per entry.
// Ports:
//   clk, rst        : clock, synchronous active-high reset
//   start           : one-cycle pulse, begins a pass from IDLE/DONE/ERR
//   rom_addr/data   : async-read config ROM, rom_addr tracks cur
//   i2c_req/dev/reg/wdata : level write request to the I2C writer
//   i2c_ack/nack    : one-cycle completion pulses from the writer
//   busy/done/error : pass status, fail_addr = register that aborted
module d5m_config_seq #(
   parameter logic [7:0] DEV_ADDR   = 8'hBA,
   parameter logic [7:0] FIRST_ADDR = 8'h01,
   parameter logic [7:0] LAST_ADDR  = 8'h9F,
   parameter int         PWR_DLY    = 16,
   parameter int         GAP_CYC    = 4,
   parameter int         MAX_RETRY  = 3
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   output logic [7:0]  rom_addr,
   input  logic [15:0] rom_data,
   output logic        i2c_req,
   output logic [7:0]  i2c_dev,
   output logic [7:0]  i2c_reg,
   output logic [15:0] i2c_wdata,
   input  logic        i2c_ack,
   input  logic        i2c_nack,
   output logic        busy,
   output logic        done,
   output logic        error,
   output logic [7:0]  fail_addr
);

   typedef enum logic [2:0] {
      S_IDLE, S_WAIT, S_FETCH, S_REQ, S_GAP, S_DONE, S_ERR
   } state_t;

   localparam logic [15:0] PWR_LAST = 16'(PWR_DLY - 1);
   localparam logic [15:0] GAP_LAST = 16'(GAP_CYC - 1);
   localparam logic [2:0]  RTY_LIM  = 3'(MAX_RETRY);

   state_t      state, state_n;
   logic [7:0]  cur, cur_n;
   logic [2:0]  retry, retry_n;
   logic [15:0] cnt, cnt_n;
   logic        refetch, refetch_n;
   logic [7:0]  reg_q, reg_n;
   logic [15:0] wd_q, wd_n;
   logic [7:0]  fail_q, fail_n;

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= S_IDLE;
         cur     <= FIRST_ADDR;
         retry   <= '0;
         cnt     <= '0;
         refetch <= 1'b0;
         reg_q   <= '0;
         wd_q    <= '0;
         fail_q  <= '0;
      end else begin
         state   <= state_n;
         cur     <= cur_n;
         retry   <= retry_n;
         cnt     <= cnt_n;
         refetch <= refetch_n;
         reg_q   <= reg_n;
         wd_q    <= wd_n;
         fail_q  <= fail_n;
      end
   end

   always_comb begin
      state_n   = state;
      cur_n     = cur;
      retry_n   = retry;
      cnt_n     = cnt;
      refetch_n = refetch;
      reg_n     = reg_q;
      wd_n      = wd_q;
      fail_n    = fail_q;
      unique case (state)
         S_IDLE, S_DONE, S_ERR: begin
            if (start) begin
               cur_n   = FIRST_ADDR;
               retry_n = '0;
               cnt_n   = '0;
               // An empty range aborts at once without touching the bus.
               if (FIRST_ADDR > LAST_ADDR) begin
                  state_n = S_ERR;
                  fail_n  = FIRST_ADDR;
               end else begin
                  state_n = S_WAIT;
                  fail_n  = '0;
               end
            end
         end
         S_WAIT: begin
            if (cnt == PWR_LAST) begin
               cnt_n   = '0;
               state_n = S_FETCH;
            end else begin
               cnt_n = cnt + 16'd1;
            end
         end
         S_FETCH: begin
            reg_n   = cur;
            wd_n    = rom_data;
            state_n = S_REQ;
         end
         S_REQ: begin
            // nack wins when both pulses arrive together.
            if (i2c_nack) begin
               retry_n = retry + 3'd1;
               if (retry + 3'd1 == RTY_LIM) begin
                  state_n = S_ERR;
                  fail_n  = cur;
               end else begin
                  state_n   = S_GAP;
                  refetch_n = 1'b0;
                  cnt_n     = '0;
               end
            end else if (i2c_ack) begin
               retry_n = '0;
               // End check precedes increment so 8'hFF never wraps.
               if (cur == LAST_ADDR) begin
                  state_n = S_DONE;
               end else begin
                  cur_n     = cur + 8'd1;
                  state_n   = S_GAP;
                  refetch_n = 1'b1;
                  cnt_n     = '0;
               end
            end
         end
         S_GAP: begin
            if (cnt == GAP_LAST) begin
               cnt_n   = '0;
               state_n = refetch ? S_FETCH : S_REQ;
            end else begin
               cnt_n = cnt + 16'd1;
            end
         end
         default: state_n = S_IDLE;
      endcase
   end

   assign rom_addr  = cur;
   assign i2c_req   = (state == S_REQ);
   assign i2c_dev   = DEV_ADDR;
   assign i2c_reg   = reg_q;
   assign i2c_wdata = wd_q;
   assign busy      = (state != S_IDLE) && (state != S_DONE) &&
                      (state != S_ERR);
   assign done      = (state == S_DONE);
   assign error     = (state == S_ERR);
   assign fail_addr = fail_q;

endmodule

// File: tb/tb_d5m_config_seq.sv
// Directed scoreboard bench for d5m_config_seq.
// Expected writes are queued per pass and popped on each request.
module tb_d5m_config_seq;

   localparam int GAP = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0, ack = 1'b0, nack = 1'b0;
   logic [7:0]  rom_addr, i2c_dev, i2c_reg, fail_addr;
   logic [15:0] rom_data, i2c_wdata;
   logic        i2c_req, busy, done, error;

   logic        start2 = 1'b0, ack2 = 1'b0;
   logic [7:0]  rom_addr2, dev2, reg2, fail2;
   logic [15:0] rom_data2, wdata2;
   logic        req2, busy2, done2, error2;

   logic        start3 = 1'b0;
   logic [7:0]  rom_addr3, dev3, reg3, fail3;
   logic [15:0] wdata3;
   logic        req3, busy3, done3, error3;

   int passed = 0;
   int failed = 0;
   int total  = 0;
   bit saw_zero2 = 1'b0;
   bit saw_req3  = 1'b0;

   typedef struct packed {
      logic [7:0]  r;
      logic [15:0] d;
   } wr_t;
   wr_t expq[$];

   function automatic logic [15:0] rom(input logic [7:0] a);
      case (a)
         8'h01:   return 16'h0036;
         8'h02:   return 16'h0010;
         8'h03:   return 16'h0437;
         default: return {a, ~a};
      endcase
   endfunction

   assign rom_data  = rom(rom_addr);
   assign rom_data2 = rom(rom_addr2);

   always #5 clk = ~clk;

   d5m_config_seq #(.FIRST_ADDR(8'h01), .LAST_ADDR(8'h03)) dut (
      .clk(clk), .rst(rst), .start(start),
      .rom_addr(rom_addr), .rom_data(rom_data),
      .i2c_req(i2c_req), .i2c_dev(i2c_dev), .i2c_reg(i2c_reg),
      .i2c_wdata(i2c_wdata), .i2c_ack(ack), .i2c_nack(nack),
      .busy(busy), .done(done), .error(error), .fail_addr(fail_addr)
   );

   d5m_config_seq #(.FIRST_ADDR(8'hFE), .LAST_ADDR(8'hFF)) dut2 (
      .clk(clk), .rst(rst), .start(start2),
      .rom_addr(rom_addr2), .rom_data(rom_data2),
      .i2c_req(req2), .i2c_dev(dev2), .i2c_reg(reg2),
      .i2c_wdata(wdata2), .i2c_ack(ack2), .i2c_nack(1'b0),
      .busy(busy2), .done(done2), .error(error2), .fail_addr(fail2)
   );

   d5m_config_seq #(.FIRST_ADDR(8'h05), .LAST_ADDR(8'h04)) dut3 (
      .clk(clk), .rst(rst), .start(start3),
      .rom_addr(rom_addr3), .rom_data(16'h1234),
      .i2c_req(req3), .i2c_dev(dev3), .i2c_reg(reg3),
      .i2c_wdata(wdata3), .i2c_ack(1'b1), .i2c_nack(1'b0),
      .busy(busy3), .done(done3), .error(error3), .fail_addr(fail3)
   );

   always @(negedge clk) begin
      if (!rst && rom_addr2 == 8'h00) saw_zero2 <= 1'b1;
      if (req3) saw_req3 <= 1'b1;
   end

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else begin
         failed++;
         $error("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic go();
      start = 1'b1;
      tick();
      start = 1'b0;
      chk("busy_after_start", busy, 1);
   endtask

   task automatic wait_req(output int n);
      n = 0;
      do begin
         tick();
         n++;
      end while (!i2c_req && n < 200);
      if (!i2c_req) chk("req_timeout", i2c_req, 1);
   endtask

   task automatic chk_sb();
      wr_t e;
      chk("sb_nonempty", expq.size() != 0, 1);
      if (expq.size() != 0) begin
         e = expq.pop_front();
         chk("wr_reg", i2c_reg, e.r);
         chk("wr_data", i2c_wdata, e.d);
      end
   endtask

   task automatic serve(input bit is_nack, input int dly, output int n);
      wait_req(n);
      chk_sb();
      repeat (dly) tick();
      chk("req_hold", i2c_req, 1);
      ack  = !is_nack;
      nack = is_nack;
      tick();
      ack  = 1'b0;
      nack = 1'b0;
      chk("req_drop", i2c_req, 0);
   endtask

   task automatic push(input logic [7:0] r);
      expq.push_back({r, rom(r)});
   endtask

   initial begin
      int n;
      repeat (3) tick();
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_error", error, 0);
      chk("rst_req", i2c_req, 0);
      chk("rst_rom_addr", rom_addr, 8'h01);
      chk("rst_reg", i2c_reg, 0);
      chk("rst_wdata", i2c_wdata, 0);
      chk("rst_fail", fail_addr, 0);
      chk("dev", i2c_dev, 8'hBA);
      chk("rst_rom_addr2", rom_addr2, 8'hFE);
      rst = 1'b0;
      tick();

      // Clean pass, ack two cycles after each request.
      push(8'h01); push(8'h02); push(8'h03);
      go();
      serve(0, 2, n);
      chk("first_req_lat", n + 1, 18);
      serve(0, 2, n);
      chk("ack_gap", n, GAP + 1);
      serve(0, 2, n);
      chk("p1_done", done, 1);
      chk("p1_busy", busy, 0);
      chk("p1_error", error, 0);
      chk("p1_sb_empty", expq.size(), 0);

      // Two nacks then ack on reg 2.
      push(8'h01); push(8'h02); push(8'h02); push(8'h02); push(8'h03);
      go();
      serve(0, 2, n);
      serve(1, 1, n);
      serve(1, 1, n);
      chk("retry_gap1", n, GAP);
      serve(0, 1, n);
      chk("retry_gap2", n, GAP);
      serve(0, 1, n);
      chk("p2_refetch_gap", n, GAP + 1);
      chk("p2_done", done, 1);
      chk("p2_error", error, 0);

      // Three nacks on reg 2 abort the pass.
      push(8'h01); push(8'h02); push(8'h02); push(8'h02);
      go();
      serve(0, 2, n);
      serve(1, 0, n);
      serve(1, 0, n);
      serve(1, 0, n);
      chk("p3_error", error, 1);
      chk("p3_fail", fail_addr, 8'h02);
      chk("p3_busy", busy, 0);
      chk("p3_done", done, 0);
      n = 0;
      repeat (40) begin
         tick();
         if (i2c_req) n++;
      end
      chk("p3_no_more_req", n, 0);
      chk("p3_hold_error", error, 1);

      // Start ignored mid-request; ack+nack counts as nack.
      push(8'h01); push(8'h02);
      go();
      chk("restart_clr_fail", fail_addr, 0);
      serve(0, 2, n);
      wait_req(n);
      chk_sb();
      start = 1'b1;
      tick();
      start = 1'b0;
      chk("start_ign_req", i2c_req, 1);
      chk("start_ign_reg", i2c_reg, 8'h02);
      ack = 1'b1; nack = 1'b1;
      tick();
      ack = 1'b0; nack = 1'b0;
      chk("both_req_drop", i2c_req, 0);
      chk("both_busy", busy, 1);
      push(8'h02); push(8'h02);
      serve(1, 0, n);
      chk("both_retry_gap", n, GAP);
      serve(1, 0, n);
      chk("both_err", error, 1);
      chk("both_fail", fail_addr, 8'h02);

      // Reset mid-request, with start and ack in the same cycle.
      push(8'h01); push(8'h02);
      go();
      serve(0, 2, n);
      wait_req(n);
      chk_sb();
      rst = 1'b1; start = 1'b1; ack = 1'b1;
      tick();
      rst = 1'b0; start = 1'b0; ack = 1'b0;
      chk("mid_rst_req", i2c_req, 0);
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_done", done, 0);
      chk("mid_rst_error", error, 0);
      chk("mid_rst_reg", i2c_reg, 0);
      chk("mid_rst_wdata", i2c_wdata, 0);
      chk("mid_rst_rom", rom_addr, 8'h01);
      tick();
      chk("mid_rst_idle", busy, 0);
      push(8'h01); push(8'h02); push(8'h03);
      go();
      serve(0, 1, n);
      chk("restart_lat", n + 1, 18);
      serve(0, 1, n);
      serve(0, 1, n);
      chk("restart_done", done, 1);

      // Top-of-range pass FE..FF.
      start2 = 1'b1;
      tick();
      start2 = 1'b0;
      for (int k = 0; k < 2; k++) begin
         logic [7:0] ea;
         ea = (k == 0) ? 8'hFE : 8'hFF;
         n = 0;
         do begin
            tick();
            n++;
         end while (!req2 && n < 200);
         chk("hi_req", req2, 1);
         chk("hi_reg", reg2, ea);
         chk("hi_data", wdata2, rom(ea));
         ack2 = 1'b1;
         tick();
         ack2 = 1'b0;
      end
      n = 0;
      repeat (30) begin
         tick();
         if (req2) n++;
      end
      chk("hi_done", done2, 1);
      chk("hi_extra_req", n, 0);
      chk("hi_no_wrap", saw_zero2, 0);
      chk("hi_rom_addr", rom_addr2, 8'hFF);

      // Empty range goes straight to error.
      start3 = 1'b1;
      tick();
      start3 = 1'b0;
      chk("empty_err", error3, 1);
      chk("empty_fail", fail3, 8'h05);
      chk("empty_busy", busy3, 0);
      repeat (5) tick();
      chk("empty_no_req", saw_req3, 0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/d5m_config_seq.md
D5M_CONFIG_SEQ -- requirements
Module: d5m_config_seq

Interface
REQ-001 Parameter DEV_ADDR, default 8'hBA, is the I2C device write address driven on i2c_dev.
REQ-002 Parameter FIRST_ADDR, default 8'h01, is the first register/ROM address written.
REQ-003 Parameter LAST_ADDR, default 8'h9F, is the last register/ROM address written (inclusive).
REQ-004 Parameter PWR_DLY, default 16, is the clk cycles waited after start before the first fetch (>=1).
REQ-005 Parameter GAP_CYC, default 4, is the idle clk cycles between consecutive I2C requests (>=1).
REQ-006 Parameter MAX_RETRY, default 3, is the NACKed attempts per register before abort (1..7).
REQ-007 clk  input  1  sole clock; all logic on rising edge.
REQ-008 rst  input  1  synchronous, active-high reset.
REQ-009 start  input  1  one-cycle pulse; begins a configuration pass.
REQ-010 rom_addr  output  8  address to the config ROM (asynchronous-read ROM, data valid same cycle).
REQ-011 rom_data  input  16  ROM word for rom_addr.
REQ-012 i2c_req  output  1  write request to I2C writer; level, held until ack or nack.
REQ-013 i2c_dev  output  8  device address, constant DEV_ADDR.
REQ-014 i2c_reg  output  8  register address of current write.
REQ-015 i2c_wdata  output  16  data of current write.
REQ-016 i2c_ack  input  1  one-cycle pulse: write completed, ACKed.
REQ-017 i2c_nack  input  1  one-cycle pulse: write failed (any NACK).
REQ-018 busy  output  1  high in any state other than IDLE, DONE, ERR.
REQ-019 done  output  1  high in DONE.
REQ-020 error  output  1  high in ERR.
REQ-021 fail_addr  output  8  register address that caused ERR; 0 otherwise.

Function
REQ-022 States: IDLE, WAIT, FETCH, REQ, GAP, DONE, ERR.
REQ-023 IDLE/DONE/ERR + start -> WAIT; cur=FIRST_ADDR, retry count=0, delay counter=0, fail_addr=0; start in other states ignored.
REQ-024 If FIRST_ADDR > LAST_ADDR, start -> ERR with fail_addr=FIRST_ADDR, no request issued.
REQ-025 WAIT lasts exactly PWR_DLY cycles, then -> FETCH.
REQ-026 FETCH lasts one cycle: rom_addr=cur; rom_data latched into i2c_wdata, cur into i2c_reg, at end of cycle; -> REQ.
REQ-027 rom_addr = cur in all states.
REQ-028 REQ: i2c_req=1, i2c_reg/i2c_wdata stable; first request cycle is the cycle after FETCH.
REQ-029 REQ + i2c_ack: i2c_req low next cycle; retry count=0; if cur==LAST_ADDR -> DONE, else cur=cur+1, -> GAP then FETCH.
REQ-030 REQ + i2c_nack: retry count+1; if new count==MAX_RETRY -> ERR, fail_addr=cur; else -> GAP then REQ (same address/data, no refetch).
REQ-031 ack and nack in same cycle: treated as nack.
REQ-032 ack/nack outside REQ: ignored.
REQ-033 GAP lasts exactly GAP_CYC cycles with i2c_req=0.
REQ-034 End-of-range compared before increment; LAST_ADDR=8'hFF never wraps cur to 8'h00.
REQ-035 i2c_req asserted only in REQ; exactly LAST_ADDR-FIRST_ADDR+1 ACKed writes per successful pass, ascending.
REQ-036 DONE and ERR hold outputs until rst or start.

Reset
REQ-037 rst (any state, including mid-REQ) next edge: state IDLE, i2c_req=0, busy=0, done=0, error=0, fail_addr=0, cur=FIRST_ADDR, rom_addr=FIRST_ADDR, i2c_reg=0, i2c_wdata=0, counters 0.
REQ-038 rst has priority over start, ack, nack in the same cycle.

Verification
REQ-039 FIRST=1,LAST=3, ROM[1..3]=0x0036,0x0010,0x0437, ack 2 cycles after each req -> three writes (01,0036),(02,0010),(03,0437), done=1, first req 18 cycles after start (PWR_DLY=16).
REQ-040 nack on first two attempts of reg 0x02, ack third -> reg 0x02 requested 3 times, same data, GAP_CYC=4 idle between; done=1, error=0.
REQ-041 nack three times on reg 0x02 -> error=1, fail_addr=0x02, busy=0, reg 0x03 never requested.
REQ-042 FIRST=8'hFE,LAST=8'hFF -> writes to FE, FF only, then DONE; rom_addr never 00 after FF.
REQ-043 rst asserted while i2c_req=1 on reg 0x02 -> next cycle i2c_req=0, IDLE; subsequent start restarts at reg 0x01.
REQ-044 start pulsed during REQ, and simultaneous ack+nack -> start ignored; same register retried, retry count 1.
